exhaustive_sweep_capture: RTL and testbench

//  Upstream driver and response collector for a small combinational or sequential DUT under trojan test.

---
 rtl/exhaustive_sweep_capture.sv | 130 +++++++++++++
 tb/tb_exhaustive_sweep_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_sweep_capture.sv
// rtl/exhaustive_sweep_capture.sv - exhaustive input sweep driver with capture stream, MISR and ones count
module exhaustive_sweep_capture #(
   parameter int                N_IN   = 5,
   parameter int                N_OUT  = 1,
   parameter int                SETTLE = 1,
   parameter int                SIG_W  = 16,
   parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
   parameter logic [SIG_W-1:0]  SEED   = 16'h0000
) (
   input  logic                              CK,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              abort,
   output logic [N_IN-1:0]                   vec_out,
   output logic                              vec_valid,
   input  logic [N_OUT-1:0]                  resp_in,
   output logic                              cap_valid,
   input  logic                              cap_ready,
   output logic [N_IN-1:0]                   cap_vec,
   output logic [N_OUT-1:0]                  cap_resp,
   output logic                              busy,
   output logic                              done,
   output logic [SIG_W-1:0]                  signature,
   output logic [N_IN+$clog2(N_OUT+1)-1:0]   ones_cnt
);

   localparam int CNT_W = N_IN + $clog2(N_OUT + 1);
   localparam int SCW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SAMPLE,
      ST_EMIT,
      ST_DONE
   } state_t;

   state_t           state;
   logic [SCW-1:0]   settle_cnt;
   logic [SIG_W-1:0] misr_next;
   logic [CNT_W-1:0] resp_ones;

   function automatic logic [CNT_W-1:0] popcount(input logic [N_OUT-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < N_OUT; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   always_comb begin
      misr_next = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? POLY : '0)
                ^ SIG_W'(resp_in);
      resp_ones = popcount(resp_in);
   end

   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         vec_out    <= '0;
         vec_valid  <= 1'b0;
         cap_valid  <= 1'b0;
         cap_vec    <= '0;
         cap_resp   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         signature  <= SEED;
         ones_cnt   <= '0;
      end else if (abort && state != ST_IDLE) begin
         // partial signature and count are kept for inspection after an abort
         state     <= ST_IDLE;
         vec_out   <= '0;
         vec_valid <= 1'b0;
         cap_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  vec_out    <= '0;
                  signature  <= SEED;
                  ones_cnt   <= '0;
                  settle_cnt <= '0;
                  done       <= 1'b0;
                  vec_valid  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_SAMPLE: begin
               cap_vec   <= vec_out;
               cap_resp  <= resp_in;
               signature <= misr_next;
               ones_cnt  <= ones_cnt + resp_ones;
               cap_valid <= 1'b1;
               state     <= ST_EMIT;
            end
            ST_EMIT: begin
               if (cap_ready) begin
                  cap_valid <= 1'b0;
                  if (&vec_out) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     vec_valid <= 1'b0;
                     state     <= ST_DONE;
                  end else begin
                     vec_out    <= vec_out + 1'b1;
                     settle_cnt <= '0;
                     state      <= ST_APPLY;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
// tb/tb_exhaustive_sweep_capture.sv - randomized self-checking bench for exhaustive_sweep_capture
module tb_exhaustive_sweep_capture;

   logic        CK;
   logic        reset;
   logic        start;
   logic        abort;
   logic [4:0]  vec_out;
   logic        vec_valid;
   logic [0:0]  resp_in;
   logic        cap_valid;
   logic        cap_ready;
   logic [4:0]  cap_vec;
   logic [0:0]  cap_resp;
   logic        busy;
   logic        done;
   logic [15:0] signature;
   logic [5:0]  ones_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mode     = 0;
   int          rmode    = 0;
   int          stalled  = 0;
   int          exp_idx  = 0;
   bit          poke     = 0;
   logic [31:0] lut_bits = '0;
   logic [15:0] sig_after [32];
   int          ones_after [32];

   exhaustive_sweep_capture dut (
      .CK(CK), .reset(reset), .start(start), .abort(abort),
      .vec_out(vec_out), .vec_valid(vec_valid), .resp_in(resp_in),
      .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_vec(cap_vec),
      .cap_resp(cap_resp), .busy(busy), .done(done),
      .signature(signature), .ones_cnt(ones_cnt)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // Device under trojan test: a purely combinational response of the applied vector.
   always_comb begin
      case (mode)
         0:       resp_in = 1'b0;
         1:       resp_in = 1'b1;
         2:       resp_in = ^vec_out;
         default: resp_in = lut_bits[vec_out];
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic resp_of(input int k);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return ($countones(k[4:0]) % 2) == 1;
         default: return lut_bits[k];
      endcase
   endfunction

   task automatic build_model();
      logic [15:0] s;
      int          o;
      s = 16'h0000;
      o = 0;
      for (int k = 0; k < 32; k++) begin
         logic r;
         r = resp_of(k);
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
         o = o + int'(r);
         sig_after[k]  = s;
         ones_after[k] = o;
      end
   endtask

   // Consumer side: ready policy applied just after each rising edge.
   always @(posedge CK) begin
      #1;
      case (rmode)
         0: cap_ready = 1'b1;
         1: cap_ready = 1'($urandom_range(0, 1));
         default: begin
            if (cap_valid && cap_vec == 5'd3 && stalled < 5) begin
               cap_ready = 1'b0;
               stalled++;
            end else begin
               cap_ready = 1'b1;
            end
         end
      endcase
      if (poke) start = busy && ($urandom_range(0, 3) == 0);
   end

   // Every cycle a pair is offered, it must be the next vector of the sweep with model results.
   always @(negedge CK) begin
      if (reset && cap_valid) begin
         if (exp_idx > 31) begin
            check("capture_overrun", 32'(exp_idx), 32'd31);
         end else begin
            check("cap_vec",   32'(cap_vec),   32'(exp_idx));
            check("cap_resp",  32'(cap_resp),  32'(resp_of(exp_idx)));
            check("vec_held",  32'(vec_out),   32'(exp_idx));
            check("run_sig",   32'(signature), 32'(sig_after[exp_idx]));
            check("run_ones",  32'(ones_cnt),  32'(ones_after[exp_idx]));
            check("busy_emit", 32'(busy && vec_valid && !done), 32'd1);
         end
         if (cap_ready) exp_idx++;
      end
   end

   task automatic run_sweep(input int m, input int rm, input int exp_cycles);
      int cyc;
      mode    = m;
      rmode   = rm;
      stalled = 0;
      build_model();
      @(negedge CK);
      exp_idx = 0;
      start   = 1'b1;
      @(negedge CK);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 3000) begin
         @(negedge CK);
         cyc++;
      end
      check("done_seen", 32'(done), 32'd1);
      if (exp_cycles > 0) check("sweep_cycles", 32'(cyc), 32'(exp_cycles));
      check("captures",  32'(exp_idx),   32'd32);
      check("final_sig", 32'(signature), 32'(sig_after[31]));
      check("final_ones", 32'(ones_cnt), 32'(ones_after[31]));
      check("final_vec", 32'(vec_out),   32'd31);
      check("final_flags", {28'b0, busy, vec_valid, cap_valid, done}, 32'h1);
   endtask

   task automatic start_and_wait_vec(input int m, input int v, input bit need_cap);
      int cyc;
      mode  = m;
      rmode = 0;
      build_model();
      @(negedge CK);
      exp_idx = 0;
      start   = 1'b1;
      @(negedge CK);
      start = 1'b0;
      cyc   = 0;
      while (!(vec_out == 5'(v) && (!need_cap || cap_valid)) && cyc < 1000) begin
         @(negedge CK);
         cyc++;
      end
      check("reach_vec", 32'(cyc < 1000), 32'd1);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      cap_ready = 1'b1;
      #1;
      check("rst_flags", {28'b0, busy, vec_valid, cap_valid, done}, 32'h0);
      check("rst_vals",  {vec_out, cap_vec, ones_cnt, 15'b0, cap_resp}, 32'h0);
      check("rst_sig",   32'(signature), 32'h0);
      @(negedge CK);
      reset = 1'b1;

      // Pin the model against hand-derived values.
      mode = 1; build_model();
      check("model_c1_sig3",  32'(sig_after[3]),  32'h000F);
      check("model_c1_sig16", 32'(sig_after[16]), 32'hEFDE);
      check("model_c1_ones",  32'(ones_after[31]), 32'd32);
      mode = 2; build_model();
      check("model_par_ones", 32'(ones_after[31]), 32'd16);
      mode = 0; build_model();
      check("model_zero_sig", 32'(sig_after[31]), 32'h0);

      run_sweep(0, 0, 97);
      run_sweep(1, 0, 97);
      run_sweep(2, 0, 97);
      lut_bits = $urandom();
      run_sweep(3, 2, 102);

      // Abort near vector 10.
      lut_bits = $urandom();
      start_and_wait_vec(3, 10, 1'b0);
      abort = 1'b1;
      @(negedge CK);
      abort = 1'b0;
      check("abort_flags", {28'b0, busy, vec_valid, cap_valid, done}, 32'h0);
      check("abort_vec",   32'(vec_out), 32'h0);
      check("abort_ones",  32'((ones_cnt == 6'(ones_after[9])  && signature == sig_after[9]) ||
                               (ones_cnt == 6'(ones_after[10]) && signature == sig_after[10])), 32'd1);
      repeat (3) @(negedge CK);
      check("abort_stays_idle", {28'b0, busy, vec_valid, cap_valid, done}, 32'h0);

      // Asynchronous reset while a pair is being offered.
      start_and_wait_vec(1, 7, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("async_flags", {28'b0, busy, vec_valid, cap_valid, done}, 32'h0);
      check("async_vals",  {vec_out, cap_vec, ones_cnt, 15'b0, cap_resp}, 32'h0);
      check("async_sig",   32'(signature), 32'h0);
      @(negedge CK);
      reset = 1'b1;
      run_sweep(0, 0, 97);

      // Start pulses while busy must be ignored; a start in DONE gives a clean sweep.
      poke = 1'b1;
      run_sweep(2, 0, 97);
      poke  = 1'b0;
      start = 1'b0;
      run_sweep(1, 1, 0);

      for (int t = 0; t < 4; t++) begin
         lut_bits = $urandom();
         run_sweep(3, 1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
